distribuidor_canais: RTL and testbench
======================================

Name: distribuidor_canais

Overview:
- Inverse of the 4:1 router.
- Accepts one N-bit word per cycle from a single input channel (Entrada).
- Delivers the word to one of four output channels (A, B, C, D) chosen by SEL.
- Each output has a one-entry registered buffer and a valid/ready handshake, so a stalled destination never corrupts or drops data for the other channels.

Parameters:
- N, 4, data width in bits of Entrada and of each output channel.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Entrada  input  N  input data word.
- SEL  input  2  destination select: 00=A, 01=B, 10=C, 11=D.
- in_valid  input  1  Entrada/SEL hold a word to transfer.
- in_ready  output  1  distributor can accept the word this cycle.
- Saida_A, Saida_B, Saida_C, Saida_D  output  N each  output data registers.
- valid_A, valid_B, valid_C, valid_D  output  1 each  matching output register holds a word.
- ready_A, ready_B, ready_C, ready_D  input  1 each  downstream consumer accepts the word this cycle.

Behaviour:
- Reset: synchronous, active-high. On a clock edge with reset=1:
  - all Saida_x = 0 and all valid_x = 0;
  - any in-flight word is discarded;
  - counters (if enabled) = 0.
  - Reset overrides any simultaneous handshake.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready at a rising edge.
  - Output transfer on channel x occurs when valid_x & ready_x at a rising edge.
- in_ready is combinational: in_ready = ~valid_sel | ready_sel, where sel is the channel addressed by the current SEL. It depends only on SEL, valid_x and ready_x, never on in_valid.
- Latency: one cycle. A word accepted at edge k appears on Saida_sel with valid_sel=1 after edge k.
- Per-channel buffer update, channel x, each edge:
  - load: input transfer addressed to x → Saida_x <= Entrada, valid_x <= 1;
  - drain only: output transfer on x with no load → valid_x <= 0, Saida_x holds its last value;
  - simultaneous drain and load on x → new word loaded, valid_x stays 1; no bubble, no loss;
  - otherwise hold.
- Full channel: valid_x=1, ready_x=0 and SEL addresses x → in_ready=0. The input stalls and the word must be held by the source. Other channels continue draining normally.
- Only the addressed channel can load in a given cycle. Unaddressed channels are unaffected by Entrada.
- Stability: while valid_x=1 and ready_x=0, Saida_x must not change.
- SEL or Entrada may change while in_valid=0 without effect.

Optional Feature:
- Macro: DISTRIBUIDOR_CONTADOR_EN.
- With the macro defined:
  - adds outputs cont_A..cont_D, 8 bits each;
  - each counter increments on every output transfer of its channel;
  - counters wrap 255→0, reset to 0 and are registered.
- Without the macro: counter ports and logic are absent.

Decomposition:
- Shared package distribuidor_pkg:
  - localparam NCANAIS = 4;
  - typedef enum logic [1:0] canal_t {CANAL_A=2'b00, CANAL_B=2'b01, CANAL_C=2'b10, CANAL_D=2'b11};
  - constant CONT_W = 8.
- Sub-module canal_buffer:
  - one-entry register with load/valid/ready, parameterised by N;
  - instantiated four times.
- Top level: SEL decode, in_ready mux, optional counters.

Test Plan:
- Reset: drive reset=1 for 2 cycles with in_valid=1 → all valid_x=0, all Saida_x=0, in_ready=1 after reset release.
- Routing: all ready_x=1; send 4'hA/SEL=00, 4'hB/01, 4'hC/10, 4'hD/11 on consecutive cycles → each word appears one cycle later on Saida_A..D respectively, with a single-cycle valid pulse each.
- Backpressure: ready_B=0; send 4'h5 to B, then 4'h6 to B → in_ready=0 on the second word; Saida_B stays 4'h5. Raise ready_B → 4'h5 drains, 4'h6 loads the same edge, valid_B stays 1.
- Isolation: channel C full and stalled; send 4'h3 to D → accepted, Saida_D=4'h3 next cycle; Saida_C unchanged.
- Mid-operation reset: valid_A=1 with ready_A=0; assert reset for one edge → valid_A=0, Saida_A=0; the next word to A is accepted normally.
- Counters (DISTRIBUIDOR_CONTADOR_EN defined): 257 transfers to D with ready_D=1 → cont_D=1 (wrapped); cont_A..cont_C=0.

Source files
------------

// File: rtl/distribuidor_pkg.sv
// Shared definitions for the 1:4 channel distributor and its per-channel buffers.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Contents: channel count, channel enumeration, counter width, SEL one-hot decoder.
package distribuidor_pkg;

  localparam int NCANAIS = 4;
  localparam int CONT_W  = 8;

  typedef enum logic [1:0] {
    CANAL_A = 2'b00,
    CANAL_B = 2'b01,
    CANAL_C = 2'b10,
    CANAL_D = 2'b11
  } canal_t;

  // One-hot decode of a channel number.
  function automatic logic [NCANAIS-1:0] decodifica(input canal_t sel);
    logic [NCANAIS-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/canal_buffer.sv
// One-entry registered output buffer with a valid/ready handshake.
// Latency: one cycle from i_load to o_valid/o_dat.
// Backpressure: holds o_dat stable while o_valid=1 and i_ready=0; load and drain may coincide.
//
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   i_load, i_dat - write strobe and data from the distributor (caller guarantees room)
//   i_ready       - downstream accepts the current word
//   o_valid,o_dat - buffer state
module canal_buffer #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic [N-1:0] i_dat,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [N-1:0] o_dat
);

  logic         r_valid;
  logic [N-1:0] r_dat;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_dat   <= '0;
    end else if (i_load) begin
      // Load wins over a simultaneous drain: the old word leaves and the new one
      // takes its place on the same edge, so valid stays high with no bubble.
      r_valid <= 1'b1;
      r_dat   <= i_dat;
    end else if (r_valid && i_ready) begin
      // Drain only: data is kept, only the valid flag drops.
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_dat   = r_dat;

endmodule

// File: rtl/distribuidor_canais.sv
// 1:4 distributor: routes one input word per cycle to output channel A..D selected by SEL.
// Latency: one cycle from the input handshake to valid on the chosen channel.
// Backpressure: in_ready drops only when the addressed channel is full and stalled; other channels keep draining.
//
// Ports:
//   clock, reset                  - system clock, synchronous active-high reset
//   Entrada, SEL, in_valid        - input word, destination (00=A..11=D), valid
//   in_ready                      - combinational: ~valid_sel | ready_sel
//   Saida_x, valid_x, ready_x     - per-channel output data/valid, downstream ready
//   cont_x (DISTRIBUIDOR_CONTADOR_EN only) - 8-bit wrapping count of output transfers per channel
module distribuidor_canais
  import distribuidor_pkg::*;
#(
  parameter int N = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N-1:0]      Entrada,
  input  logic [1:0]        SEL,
  input  logic              in_valid,
`ifdef DISTRIBUIDOR_CONTADOR_EN
  output logic [CONT_W-1:0] cont_A,
  output logic [CONT_W-1:0] cont_B,
  output logic [CONT_W-1:0] cont_C,
  output logic [CONT_W-1:0] cont_D,
`endif
  output logic              in_ready,
  output logic [N-1:0]      Saida_A,
  output logic [N-1:0]      Saida_B,
  output logic [N-1:0]      Saida_C,
  output logic [N-1:0]      Saida_D,
  output logic              valid_A,
  output logic              valid_B,
  output logic              valid_C,
  output logic              valid_D,
  input  logic              ready_A,
  input  logic              ready_B,
  input  logic              ready_C,
  input  logic              ready_D
);

  canal_t               w_sel;
  logic [NCANAIS-1:0]   w_sel_oh;
  logic [NCANAIS-1:0]   w_valid;
  logic [NCANAIS-1:0]   w_ready;
  logic [NCANAIS-1:0]   w_load;
  logic [N-1:0]         w_dat [NCANAIS];
  logic                 w_in_xfer;

  assign w_sel    = canal_t'(SEL);
  assign w_sel_oh = decodifica(w_sel);
  assign w_ready  = {ready_D, ready_C, ready_B, ready_A};

  // Independent of in_valid so the source may look at it before committing a word.
  assign in_ready  = ~w_valid[w_sel] | w_ready[w_sel];
  assign w_in_xfer = in_valid & in_ready;
  assign w_load    = w_sel_oh & {NCANAIS{w_in_xfer}};

  for (genvar g = 0; g < NCANAIS; g++) begin : g_canal
    canal_buffer #(.N(N)) u_buf (
      .clock   (clock),
      .reset   (reset),
      .i_load  (w_load[g]),
      .i_dat   (Entrada),
      .i_ready (w_ready[g]),
      .o_valid (w_valid[g]),
      .o_dat   (w_dat[g])
    );
  end

  assign Saida_A = w_dat[0];
  assign Saida_B = w_dat[1];
  assign Saida_C = w_dat[2];
  assign Saida_D = w_dat[3];
  assign valid_A = w_valid[0];
  assign valid_B = w_valid[1];
  assign valid_C = w_valid[2];
  assign valid_D = w_valid[3];

`ifdef DISTRIBUIDOR_CONTADOR_EN
  logic [CONT_W-1:0] r_cont [NCANAIS];

  for (genvar g = 0; g < NCANAIS; g++) begin : g_cont
    always_ff @(posedge clock) begin
      if (reset) begin
        r_cont[g] <= '0;
      end else if (w_valid[g] && w_ready[g]) begin
        r_cont[g] <= r_cont[g] + 1'b1;  // wraps 255 -> 0
      end
    end
  end

  assign cont_A = r_cont[0];
  assign cont_B = r_cont[1];
  assign cont_C = r_cont[2];
  assign cont_D = r_cont[3];
`endif

endmodule

// File: tb/tb_distribuidor_canais.sv
// Directed self-checking bench for distribuidor_canais.
// Inputs change 1 time unit after the rising edge; outputs are read there too.
module tb_distribuidor_canais;

  localparam int N = 4;

  logic         clock;
  logic         reset;
  logic [N-1:0] Entrada;
  logic [1:0]   SEL;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] Saida_A, Saida_B, Saida_C, Saida_D;
  logic         valid_A, valid_B, valid_C, valid_D;
  logic         ready_A, ready_B, ready_C, ready_D;
`ifdef DISTRIBUIDOR_CONTADOR_EN
  logic [7:0]   cont_A, cont_B, cont_C, cont_D;
`endif

  int total;
  int bad;

  distribuidor_canais #(.N(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .Entrada  (Entrada),
    .SEL      (SEL),
    .in_valid (in_valid),
`ifdef DISTRIBUIDOR_CONTADOR_EN
    .cont_A   (cont_A),
    .cont_B   (cont_B),
    .cont_C   (cont_C),
    .cont_D   (cont_D),
`endif
    .in_ready (in_ready),
    .Saida_A  (Saida_A),
    .Saida_B  (Saida_B),
    .Saida_C  (Saida_C),
    .Saida_D  (Saida_D),
    .valid_A  (valid_A),
    .valid_B  (valid_B),
    .valid_C  (valid_C),
    .valid_D  (valid_D),
    .ready_A  (ready_A),
    .ready_B  (ready_B),
    .ready_C  (ready_C),
    .ready_D  (ready_D)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [N-1:0] d);
    in_valid = v;
    SEL      = s;
    Entrada  = d;
  endtask

  task automatic test_reset();
    ready_A = 1'b1; ready_B = 1'b1; ready_C = 1'b1; ready_D = 1'b1;
    drive(1'b1, 2'b00, 4'hF);
    reset = 1'b1;
    step();
    step();
    total++;
    if ({valid_A, valid_B, valid_C, valid_D} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_valid: got %b want 0000", {valid_A, valid_B, valid_C, valid_D});
    end
    total++;
    if ({Saida_A, Saida_B, Saida_C, Saida_D} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_data: got %h want 0000", {Saida_A, Saida_B, Saida_C, Saida_D});
    end
    reset = 1'b0;
    drive(1'b0, 2'b00, 4'h0);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_routing();
    logic [N-1:0] words [4];
    logic [N-1:0] got;
    logic [3:0]   vld;
    words[0] = 4'hA; words[1] = 4'hB; words[2] = 4'hC; words[3] = 4'hD;
    ready_A = 1'b1; ready_B = 1'b1; ready_C = 1'b1; ready_D = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), words[i]);
      step();
      vld = {valid_D, valid_C, valid_B, valid_A};
      case (i)
        0: got = Saida_A;
        1: got = Saida_B;
        2: got = Saida_C;
        default: got = Saida_D;
      endcase
      total++;
      if (vld !== (4'b0001 << i)) begin
        bad++;
        $display("FAIL route_valid_%0d: got %b want %b", i, vld, 4'b0001 << i);
      end
      total++;
      if (got !== words[i]) begin
        bad++;
        $display("FAIL route_data_%0d: got %h want %h", i, got, words[i]);
      end
    end
    drive(1'b0, 2'b00, 4'h0);
    step();
    total++;
    if ({valid_D, valid_C, valid_B, valid_A} !== 4'b0000) begin
      bad++;
      $display("FAIL route_drained: got %b want 0000", {valid_D, valid_C, valid_B, valid_A});
    end
  endtask

  task automatic test_backpressure();
    ready_B = 1'b0;
    drive(1'b1, 2'b01, 4'h5);
    step();
    total++;
    if (valid_B !== 1'b1 || Saida_B !== 4'h5) begin
      bad++;
      $display("FAIL bp_first: got v=%b d=%h want v=1 d=5", valid_B, Saida_B);
    end
    drive(1'b1, 2'b01, 4'h6);
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_stall_ready: got %b want 0", in_ready);
    end
    step();
    total++;
    if (valid_B !== 1'b1 || Saida_B !== 4'h5) begin
      bad++;
      $display("FAIL bp_hold: got v=%b d=%h want v=1 d=5", valid_B, Saida_B);
    end
    ready_B = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    step();
    total++;
    if (valid_B !== 1'b1 || Saida_B !== 4'h6) begin
      bad++;
      $display("FAIL bp_swap: got v=%b d=%h want v=1 d=6", valid_B, Saida_B);
    end
    drive(1'b0, 2'b01, 4'h0);
    step();
    total++;
    if (valid_B !== 1'b0 || Saida_B !== 4'h6) begin
      bad++;
      $display("FAIL bp_drain: got v=%b d=%h want v=0 d=6", valid_B, Saida_B);
    end
  endtask

  task automatic test_isolation();
    ready_C = 1'b0;
    drive(1'b1, 2'b10, 4'h7);
    step();
    drive(1'b1, 2'b11, 4'h3);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL iso_ready_d: got %b want 1", in_ready);
    end
    step();
    total++;
    if (valid_D !== 1'b1 || Saida_D !== 4'h3) begin
      bad++;
      $display("FAIL iso_d: got v=%b d=%h want v=1 d=3", valid_D, Saida_D);
    end
    total++;
    if (valid_C !== 1'b1 || Saida_C !== 4'h7) begin
      bad++;
      $display("FAIL iso_c: got v=%b d=%h want v=1 d=7", valid_C, Saida_C);
    end
    // SEL/Entrada wander while in_valid=0: nothing may change.
    drive(1'b0, 2'b10, 4'h9);
    step();
    total++;
    if (valid_C !== 1'b1 || Saida_C !== 4'h7) begin
      bad++;
      $display("FAIL iso_idle_c: got v=%b d=%h want v=1 d=7", valid_C, Saida_C);
    end
    ready_C = 1'b1;
    step();
    total++;
    if (valid_C !== 1'b0) begin
      bad++;
      $display("FAIL iso_c_drain: got %b want 0", valid_C);
    end
  endtask

  task automatic test_mid_reset();
    ready_A = 1'b0;
    drive(1'b1, 2'b00, 4'h9);
    step();
    total++;
    if (valid_A !== 1'b1 || Saida_A !== 4'h9) begin
      bad++;
      $display("FAIL mr_load: got v=%b d=%h want v=1 d=9", valid_A, Saida_A);
    end
    drive(1'b1, 2'b00, 4'h2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (valid_A !== 1'b0 || Saida_A !== 4'h0) begin
      bad++;
      $display("FAIL mr_cleared: got v=%b d=%h want v=0 d=0", valid_A, Saida_A);
    end
    ready_A = 1'b1;
    drive(1'b1, 2'b00, 4'hE);
    step();
    total++;
    if (valid_A !== 1'b1 || Saida_A !== 4'hE) begin
      bad++;
      $display("FAIL mr_after: got v=%b d=%h want v=1 d=e", valid_A, Saida_A);
    end
    drive(1'b0, 2'b00, 4'h0);
    step();
  endtask

`ifdef DISTRIBUIDOR_CONTADOR_EN
  task automatic test_counters();
    ready_A = 1'b1; ready_B = 1'b1; ready_C = 1'b1; ready_D = 1'b1;
    drive(1'b0, 2'b00, 4'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 2'b11, 4'(i));
      step();
    end
    drive(1'b0, 2'b11, 4'h0);
    step();
    total++;
    if (cont_D !== 8'd1) begin
      bad++;
      $display("FAIL cnt_d: got %0d want 1", cont_D);
    end
    total++;
    if ({cont_A, cont_B, cont_C} !== 24'h0) begin
      bad++;
      $display("FAIL cnt_abc: got %h want 000000", {cont_A, cont_B, cont_C});
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(1'b0, 2'b00, 4'h0);
    ready_A = 1'b0; ready_B = 1'b0; ready_C = 1'b0; ready_D = 1'b0;
    test_reset();
    test_routing();
    test_backpressure();
    test_isolation();
    test_mid_reset();
`ifdef DISTRIBUIDOR_CONTADOR_EN
    test_counters();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
